// File: rtl/amstrad_mem_arbiter.sv
// Single-port memory slot scheduler: 4-phase bus counter, CPU/video/loader arbitration, CPU wait.
// Optional memory-ack watchdog enabled by defining ARB_TIMEOUT_EN.
module amstrad_mem_arbiter #(
    parameter logic [22:0] VRAM_BASE = 23'h000000,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ce_4p_i,
    input  logic        fast_cpu_i,
    output logic [1:0]  phase_o,
    input  logic        cpu_mreq_i,
    input  logic        cpu_rd_i,
    input  logic        cpu_wr_i,
    input  logic [22:0] cpu_addr_i,
    input  logic [7:0]  cpu_dout_i,
    output logic [7:0]  cpu_din_o,
    output logic        cpu_wait_n_o,
    input  logic [14:0] vid_addr_i,
    output logic [15:0] vid_data_o,
    output logic        vid_valid_o,
    output logic        vid_late_o,
    input  logic        ld_req_i,
    input  logic [22:0] ld_addr_i,
    input  logic [7:0]  ld_data_i,
    output logic        ld_ack_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [22:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [15:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        arb_err_o
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StBusyCpu = 2'd1;
    localparam logic [1:0] StBusyVid = 2'd2;
    localparam logic [1:0] StBusyLd  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [22:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [7:0]  cpu_din_q, cpu_din_d;
    logic        cpu_wait_n_q, cpu_wait_n_d;
    logic        cpu_done_q, cpu_done_d;
    logic [15:0] vid_data_q, vid_data_d;
    logic        vid_valid_q, vid_valid_d;
    logic        vid_late_q, vid_late_d;
    logic        ld_ack_q, ld_ack_d;

    logic        cpu_req;
    logic        cpu_pend;
    logic        done;
    logic [15:0] rdata;
    logic [22:0] vid_byte_addr;

`ifdef ARB_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        arb_err_q, arb_err_d;
`else
    logic        unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    assign cpu_req       = cpu_mreq_i & (cpu_rd_i | cpu_wr_i);
    assign cpu_pend      = cpu_req & ~cpu_done_q;
    assign vid_byte_addr = VRAM_BASE + {7'd0, vid_addr_i, 1'b0};

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_din_d   = cpu_din_q;
        cpu_done_d  = cpu_done_q;
        vid_data_d  = vid_data_q;
        vid_valid_d = 1'b0;
        vid_late_d  = 1'b0;
        ld_ack_d    = 1'b0;
        done        = 1'b0;
        rdata       = mem_rdata_i;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        arb_err_d   = arb_err_q;
`endif

        if (state_q != StIdle) begin
            if (mem_ack_i) begin
                done = 1'b1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (tmo_cnt_q == TIMEOUT - 1) begin
                // Watchdog expiry completes the requester with all-ones data.
                done      = 1'b1;
                rdata     = 16'hFFFF;
                arb_err_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
            end
`endif
        end

        if (done) begin
            mem_req_d = 1'b0;
            state_d   = StIdle;
            case (state_q)
                StBusyCpu: begin
                    if (!mem_we_q) begin
                        cpu_din_d = mem_addr_q[0] ? rdata[15:8] : rdata[7:0];
                    end
                    cpu_done_d = 1'b1;
                end
                StBusyVid: begin
                    vid_data_d  = rdata;
                    vid_valid_d = 1'b1;
                end
                StBusyLd: ld_ack_d = 1'b1;
                default: ;
            endcase
        end

        if (!cpu_mreq_i) begin
            cpu_done_d = 1'b0;
        end

        // Grants only from IDLE; a phase that arrives while busy is simply lost.
        if (ce_4p_i) begin
            phase_d = phase_q + 2'd1;
            if (state_q == StIdle) begin
                case (phase_d)
                    2'd1: begin
                        state_d    = StBusyVid;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = vid_byte_addr;
                    end
                    2'd2: begin
                        if (ld_req_i) begin
                            state_d     = StBusyLd;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = ld_addr_i;
                            mem_wdata_d = ld_data_i;
                        end else if (fast_cpu_i && cpu_pend) begin
                            state_d     = StBusyCpu;
                            mem_req_d   = 1'b1;
                            mem_we_d    = cpu_wr_i;
                            mem_addr_d  = cpu_addr_i;
                            mem_wdata_d = cpu_dout_i;
                        end
                    end
                    default: begin
                        if (cpu_pend) begin
                            state_d     = StBusyCpu;
                            mem_req_d   = 1'b1;
                            mem_we_d    = cpu_wr_i;
                            mem_addr_d  = cpu_addr_i;
                            mem_wdata_d = cpu_dout_i;
                        end
                    end
                endcase
`ifdef ARB_TIMEOUT_EN
                tmo_cnt_d = 32'd0;
`endif
            end else if (phase_d == 2'd1) begin
                vid_late_d = 1'b1;
            end
        end

        // Looks at the post-edge done flag so wait releases together with cpu_din.
        cpu_wait_n_d = ~(cpu_req & ~cpu_done_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            phase_q      <= 2'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 23'd0;
            mem_wdata_q  <= 8'd0;
            cpu_din_q    <= 8'hFF;
            cpu_wait_n_q <= 1'b1;
            cpu_done_q   <= 1'b0;
            vid_data_q   <= 16'd0;
            vid_valid_q  <= 1'b0;
            vid_late_q   <= 1'b0;
            ld_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_din_q    <= cpu_din_d;
            cpu_wait_n_q <= cpu_wait_n_d;
            cpu_done_q   <= cpu_done_d;
            vid_data_q   <= vid_data_d;
            vid_valid_q  <= vid_valid_d;
            vid_late_q   <= vid_late_d;
            ld_ack_q     <= ld_ack_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= 32'd0;
            arb_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            arb_err_q <= arb_err_d;
        end
    end
    assign arb_err_o = arb_err_q;
`else
    assign arb_err_o = 1'b0;
`endif

    assign phase_o      = phase_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign cpu_din_o    = cpu_din_q;
    assign cpu_wait_n_o = cpu_wait_n_q;
    assign vid_data_o   = vid_data_q;
    assign vid_valid_o  = vid_valid_q;
    assign vid_late_o   = vid_late_q;
    assign ld_ack_o     = ld_ack_q;

endmodule

// File: tb/tb_amstrad_mem_arbiter.sv
// Scoreboard bench for amstrad_mem_arbiter: directed slots, memory model, queued expectations.
module tb_amstrad_mem_arbiter;

    typedef struct {
        logic        we;
        logic [22:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ce = 1'b0, fast_cpu = 1'b0;
    logic [1:0]  phase;
    logic        cpu_mreq = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [22:0] cpu_addr = '0;
    logic [7:0]  cpu_dout = '0, cpu_din;
    logic        cpu_wait_n;
    logic [14:0] vid_addr = '0;
    logic [15:0] vid_data;
    logic        vid_valid, vid_late;
    logic        ld_req = 1'b0;
    logic [22:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        ld_ack;
    logic        mem_req, mem_we;
    logic [22:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack_m = 1'b0, mem_ack_man = 1'b0, mem_ack;
    logic        arb_err;

    int          total = 0, bad = 0;
    logic [1:0]  exp_phase = 2'd0;
    logic        mem_auto = 1'b1;
    int          mem_lat = 3, mem_cnt = 0;
    logic [15:0] mem_word = '0;

    txn_t        txn_q[$];
    logic [15:0] vid_q[$];
    logic [7:0]  cpu_q[$];
    logic [22:0] ld_q[$];
    logic [1:0]  late_q[$];

    assign mem_ack = mem_ack_m | mem_ack_man;

    amstrad_mem_arbiter #(.VRAM_BASE(23'h010000), .TIMEOUT(64)) dut (
        .clk_i(clk), .rst_ni(rst_n), .ce_4p_i(ce), .fast_cpu_i(fast_cpu), .phase_o(phase),
        .cpu_mreq_i(cpu_mreq), .cpu_rd_i(cpu_rd), .cpu_wr_i(cpu_wr), .cpu_addr_i(cpu_addr),
        .cpu_dout_i(cpu_dout), .cpu_din_o(cpu_din), .cpu_wait_n_o(cpu_wait_n),
        .vid_addr_i(vid_addr), .vid_data_o(vid_data), .vid_valid_o(vid_valid),
        .vid_late_o(vid_late), .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
        .ld_ack_o(ld_ack), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .arb_err_o(arb_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event expected none", name);
    endfunction

    // Memory model: acks mem_lat cycles after mem_req rises.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (mem_auto && mem_req && !mem_ack_m) begin
                if (mem_cnt == mem_lat - 1) begin
                    mem_ack_m = 1'b1;
                    mem_rdata = mem_word;
                    mem_cnt   = 0;
                end else begin
                    mem_cnt++;
                end
            end else begin
                mem_ack_m = 1'b0;
                if (!mem_req) mem_cnt = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin
        logic prev_req, prev_wait, prev_ack;
        txn_t t;
        prev_req = 1'b0; prev_wait = 1'b1; prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0; prev_wait = 1'b1; prev_ack = 1'b0;
            end else begin
                if (mem_req && !prev_req) begin
                    if (txn_q.size() == 0) unexpected("mem_req");
                    else begin
                        t = txn_q.pop_front();
                        chk("mem_addr", 32'(mem_addr), 32'(t.addr));
                        chk("mem_we", 32'(mem_we), 32'(t.we));
                        if (t.we) chk("mem_wdata", 32'(mem_wdata), 32'(t.wdata));
                    end
                end
                if (vid_valid) begin
                    if (vid_q.size() == 0) unexpected("vid_valid");
                    else chk("vid_data", 32'(vid_data), 32'(vid_q.pop_front()));
                end
                if (vid_late) begin
                    if (late_q.size() == 0) unexpected("vid_late");
                    else chk("vid_late_phase", 32'(phase), 32'(late_q.pop_front()));
                end
                if (ld_ack) begin
                    if (ld_q.size() == 0) unexpected("ld_ack");
                    else chk("ld_ack_addr", 32'(mem_addr), 32'(ld_q.pop_front()));
                end
                if (cpu_wait_n && !prev_wait) begin
                    if (cpu_q.size() == 0) unexpected("cpu_wait_rise");
                    else begin
                        chk("cpu_din", 32'(cpu_din), 32'(cpu_q.pop_front()));
                        chk("wait_after_ack", 32'(prev_ack), 32'd1);
                    end
                end
                prev_req = mem_req; prev_wait = cpu_wait_n; prev_ack = mem_ack;
            end
        end
    end

    task automatic slot(input int gap);
        ce = 1'b1;
        @(posedge clk); #1;
        ce = 1'b0;
        exp_phase = exp_phase + 2'd1;
        chk("phase", 32'(phase), 32'(exp_phase));
        repeat (gap - 1) @(posedge clk);
        #1;
    endtask

    task automatic cpu_start(input logic wr, input logic [22:0] a, input logic [7:0] d);
        cpu_mreq = 1'b1; cpu_rd = ~wr; cpu_wr = wr; cpu_addr = a; cpu_dout = d;
    endtask

    task automatic cpu_end();
        cpu_mreq = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic exp_vid(input logic [14:0] va, input logic [22:0] ba, input logic [15:0] w);
        vid_addr = va; mem_word = w;
        txn_q.push_back('{1'b0, ba, 8'h00});
        vid_q.push_back(w);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_wait_n", 32'(cpu_wait_n), 32'd1);
        chk("rst_cpu_din", 32'(cpu_din), 32'hFF);
        chk("rst_vid_data", 32'(vid_data), 32'd0);
        chk("rst_arb_err", 32'(arb_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        exp_vid(15'h1234, 23'h012468, 16'hBEEF);
        slot(8);                                     // phase 1: video
        slot(8);                                     // phase 2: idle

        cpu_start(1'b0, 23'h000101, 8'h00);
        mem_word = 16'hA55A;
        txn_q.push_back('{1'b0, 23'h000101, 8'h00});
        cpu_q.push_back(8'hA5);
        slot(8);                                     // phase 3: CPU read
        cpu_end();

        cpu_start(1'b1, 23'h000200, 8'h3C);
        txn_q.push_back('{1'b1, 23'h000200, 8'h3C});
        cpu_q.push_back(8'hA5);
        slot(8);                                     // phase 0: CPU write
        cpu_end();

        exp_vid(15'h0001, 23'h010002, 16'h1357);
        slot(8);                                     // phase 1: video

        fast_cpu = 1'b1;
        ld_req = 1'b1; ld_addr = 23'h004000; ld_data = 8'h77;
        cpu_start(1'b1, 23'h000300, 8'h11);
        txn_q.push_back('{1'b1, 23'h004000, 8'h77});
        ld_q.push_back(23'h004000);
        txn_q.push_back('{1'b1, 23'h000300, 8'h11});
        cpu_q.push_back(8'hA5);
        slot(8);                                     // phase 2: loader beats CPU
        ld_req = 1'b0;
        slot(8);                                     // phase 3: CPU write
        cpu_end();

        slot(8);                                     // phase 0: idle
        exp_vid(15'h7FFF, 23'h01FFFE, 16'h2468);
        slot(8);                                     // phase 1: video
        cpu_start(1'b0, 23'h000400, 8'h00);
        mem_word = 16'hC3D4;
        txn_q.push_back('{1'b0, 23'h000400, 8'h00});
        cpu_q.push_back(8'hD4);
        slot(8);                                     // phase 2: fast CPU read
        cpu_end();
        slot(8);                                     // phase 3: idle

        mem_lat = 20;
        cpu_start(1'b0, 23'h000033, 8'h00);
        mem_word = 16'h9E01;
        txn_q.push_back('{1'b0, 23'h000033, 8'h00});
        cpu_q.push_back(8'h9E);
        late_q.push_back(2'd1);
        slot(8);                                     // phase 0: slow CPU read
        slot(8);                                     // phase 1: lost, vid_late
        slot(8);                                     // phase 2: lost
        slot(8);                                     // phase 3: idle again
        cpu_end();
        mem_lat = 3;

        slot(8);                                     // phase 0: idle
        exp_vid(15'h0080, 23'h010100, 16'h0BAD);
        slot(8);                                     // phase 1: video
        mem_auto = 1'b0;
        ld_req = 1'b1; ld_addr = 23'h005000; ld_data = 8'h42;
        cpu_start(1'b0, 23'h000055, 8'h00);
        txn_q.push_back('{1'b1, 23'h005000, 8'h42});
        slot(4);                                     // phase 2: loader, never acked
        chk("inflight_req", 32'(mem_req), 32'd1);
        chk("inflight_wait_n", 32'(cpu_wait_n), 32'd0);
        #2 rst_n = 1'b0;
        ld_req = 1'b0; cpu_mreq = 1'b0; cpu_rd = 1'b0;
        #1;
        chk("async_mem_req", 32'(mem_req), 32'd0);
        chk("async_wait_n", 32'(cpu_wait_n), 32'd1);
        chk("async_phase", 32'(phase), 32'd0);
        exp_phase = 2'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1 mem_ack_man = 1'b1;
        @(posedge clk); #1 mem_ack_man = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("stray_ack_din", 32'(cpu_din), 32'hFF);
        chk("stray_ack_vid", 32'(vid_data), 32'd0);
        mem_auto = 1'b1;

        exp_vid(15'h0100, 23'h010200, 16'hF00D);
        slot(8);                                     // phase 1: video after reset

`ifdef ARB_TIMEOUT_EN
        repeat (3) slot(8);
        mem_auto = 1'b0;
        vid_addr = 15'h0200;
        txn_q.push_back('{1'b0, 23'h010400, 8'h00});
        vid_q.push_back(16'hFFFF);
        slot(8);
        repeat (70) @(posedge clk);
        #1;
        chk("tmo_arb_err", 32'(arb_err), 32'd1);
        chk("tmo_mem_req", 32'(mem_req), 32'd0);
        chk("tmo_wait_n", 32'(cpu_wait_n), 32'd1);
        mem_auto = 1'b1;
`else
        chk("arb_err_tied", 32'(arb_err), 32'd0);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("txn_left", 32'(txn_q.size()), 32'd0);
        chk("vid_left", 32'(vid_q.size()), 32'd0);
        chk("cpu_left", 32'(cpu_q.size()), 32'd0);
        chk("ld_left", 32'(ld_q.size()), 32'd0);
        chk("late_left", 32'(late_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
